instr_fetch_unit: RTL and testbench

//  Front end of the single-issue MIPS core: owns the PC, fetches 32-bit words from

---
 rtl/instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Purpose : Front end of the single-issue MIPS core. Owns the program counter,
//           fetches one 32-bit word at a time from instruction memory over a
//           req/ack handshake, and hands the word (with its address and opcode
//           field) to decode over a valid/ready handshake. When decode accepts
//           an instruction, the control-unit branch/jump decode and the ALU
//           zero flag pick the next PC.
//
// Parameters
//   ADDR_W    PC / instruction memory address width (expected >= 28)
//   RESET_PC  PC loaded on reset (low two bits are forced to zero)
//
// Ports
//   clk          in   core clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset, dominates everything
//   imem_req     out  fetch request, high only while in FETCH
//   imem_addr    out  word-aligned fetch address, stable for a whole fetch
//   imem_ack     in   memory presents imem_rdata this cycle
//   imem_rdata   in   fetched instruction word
//   instr        out  registered instruction for decode
//   opcode       out  instr[31:26], to the control unit
//   pc_out       out  address that instr was fetched from
//   instr_valid  out  instr/opcode/pc_out hold a live instruction
//   id_ready     in   decode accepts instr this cycle
//   branch_eq    in   control unit: current instr is beq
//   branch_ne    in   control unit: current instr is bne
//   jump         in   control unit: current instr is j
//   alu_zero     in   ALU zero flag for the current branch compare
//
// Optional build feature
//   FETCH_PERF_EN : when defined, adds perf_fetch_cnt (one count per accepted
//                   memory ack) and perf_redir_cnt (one count per accepted
//                   instruction that redirects the PC). Both are 32-bit,
//                   cleared by reset and wrap naturally. Without the macro
//                   the ports and counters do not exist and fetch behaviour
//                   is unchanged.
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    // instruction memory side
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    // decode side
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              id_ready,
    // redirect inputs from control unit / ALU
    input  logic              branch_eq,
    input  logic              branch_ne,
    input  logic              jump,
    input  logic              alu_zero
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_redir_cnt
`endif
);

    // ------------------------------------------------------------------------
    // State encoding. IDLE exists only for the single cycle after reset so the
    // first request is issued one cycle after reset is released.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10
    } fetch_state_e;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_RESET = {RESET_PC[ADDR_W-1:2], 2'b00};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              valid_q, valid_d;

    // ------------------------------------------------------------------------
    // Redirect targets, all relative to the instruction held for decode.
    // pc_out_q is always word aligned, so both targets come out aligned too.
    // All arithmetic wraps modulo 2^ADDR_W.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] branch_target;
    logic              branch_taken;
    logic              accept;
    logic              fetch_done;

    assign seq_pc        = pc_out_q + PC_STEP;
    // j keeps the top bits of the sequential PC and splices in the 26-bit index
    assign jump_target   = {seq_pc[ADDR_W-1:28], instr_q[25:0], 2'b00};
    assign branch_offset = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_target = seq_pc + branch_offset;
    // Both eq and ne together is illegal from the control unit; the OR form
    // still gives a defined answer.
    assign branch_taken  = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);

    // Handshake events. Redirect inputs are only looked at on an accept.
    assign accept     = (state_q == VALID) && valid_q && id_ready;
    assign fetch_done = (state_q == FETCH) && imem_ack;

    // ------------------------------------------------------------------------
    // Next-state and datapath update. Defaults hold every register, so acks
    // outside FETCH and any redirect inputs outside an accept have no effect.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (fetch_done) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = VALID;
                end
            end

            VALID: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                    // jump beats a taken branch beats sequential
                    if (jump) begin
                        pc_d = jump_target;
                    end else if (branch_taken) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers with synchronous reset. The instruction register resets
    // to zero, which decodes as a NOP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The request is a pure function of state, so the address it
    // carries (the PC register) cannot move until the ack is taken.
    // ------------------------------------------------------------------------
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = {pc_q[ADDR_W-1:2], 2'b00};
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters: completed fetches and PC redirects.
    // ------------------------------------------------------------------------
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (fetch_done) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (accept && (jump || branch_taken)) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            redir_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Testbench for instr_fetch_unit. Drives instruction memory and decode by
// hand, one instruction at a time. Each time an instruction is accepted the
// bench works out where the next fetch must go and queues that address; the
// queue is drained when the unit next raises its fetch request.
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        id_ready;
   logic        branch_eq;
   logic        branch_ne;
   logic        jump;
   logic        alu_zero;

   int totalCount;
   int badCount;
   logic [31:0] addrQueue[$];

   instr_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .pc_out      (pc_out),
      .instr_valid (instr_valid),
      .id_ready    (id_ready),
      .branch_eq   (branch_eq),
      .branch_ne   (branch_ne),
      .jump        (jump),
      .alu_zero    (alu_zero)
   );

   // free-running core clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock, then settle so outputs can be sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, observed, expected);
      end
   endtask

   // reference next-PC rule, computed from the accepted word and redirect inputs
   function automatic logic [31:0] nextPc(input logic [31:0] pc, input logic [31:0] word,
                                          input logic beq, input logic bne,
                                          input logic jmp, input logic zero);
      logic [31:0] seqPc;
      logic [31:0] offset;
      seqPc  = pc + 32'd4;
      offset = {{14{word[15]}}, word[15:0], 2'b00};
      if (jmp)
         return {seqPc[31:28], word[25:0], 2'b00};
      else if ((beq && zero) || (bne && !zero))
         return seqPc + offset;
      else
         return seqPc;
   endfunction

   // one complete fetch + decode transaction
   task automatic applyStimulus(input logic [31:0] word, input int ackDelay,
                                input int readyDelay, input logic beq, input logic bne,
                                input logic jmp, input logic zero);
      logic [31:0] expAddr;
      int waitCount;
      if (addrQueue.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      expAddr = addrQueue.pop_front();

      waitCount = 0;
      while (!imem_req && waitCount < 20) begin
         tick();
         waitCount++;
      end
      if (!imem_req) begin
         checkOutput("req_timeout", 32'd0, 32'd1);
         return;
      end
      checkOutput("fetch_addr", imem_addr, expAddr);

      // memory holds off its ack; request and address must not move
      for (int i = 0; i < ackDelay; i++) begin
         tick();
         checkOutput("req_held", {31'd0, imem_req}, 32'd1);
         checkOutput("addr_held", imem_addr, expAddr);
         checkOutput("no_valid_wait", {31'd0, instr_valid}, 32'd0);
      end

      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      checkOutput("valid_set", {31'd0, instr_valid}, 32'd1);
      checkOutput("instr", instr, word);
      checkOutput("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
      checkOutput("pc_out", pc_out, expAddr);
      checkOutput("req_low_valid", {31'd0, imem_req}, 32'd0);

      // decode stalls; redirect inputs and stray acks wiggle and must be ignored
      for (int i = 0; i < readyDelay; i++) begin
         id_ready   = 1'b0;
         branch_eq  = 1'($urandom);
         branch_ne  = 1'($urandom);
         jump       = 1'($urandom);
         alu_zero   = 1'($urandom);
         imem_ack   = 1'b1;
         imem_rdata = $urandom;
         tick();
         checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
         checkOutput("stall_instr", instr, word);
         checkOutput("stall_pc_out", pc_out, expAddr);
         checkOutput("stall_no_req", {31'd0, imem_req}, 32'd0);
      end

      imem_ack  = 1'b0;
      id_ready  = 1'b1;
      branch_eq = beq;
      branch_ne = bne;
      jump      = jmp;
      alu_zero  = zero;
      addrQueue.push_back(nextPc(expAddr, word, beq, bne, jmp, zero));
      tick();
      id_ready  = 1'b0;
      branch_eq = 1'b0;
      branch_ne = 1'b0;
      jump      = 1'b0;
      alu_zero  = 1'b0;
      checkOutput("valid_clear", {31'd0, instr_valid}, 32'd0);
      checkOutput("refetch_req", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      logic [31:0] pendingAddr;
      totalCount = 0;
      badCount   = 0;
      reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      id_ready   = 1'b0;
      branch_eq  = 1'b0;
      branch_ne  = 1'b0;
      jump       = 1'b0;
      alu_zero   = 1'b0;

      // reset state
      tick();
      tick();
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_instr", instr, 32'h0);
      checkOutput("rst_pc_out", pc_out, 32'h0);
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("idle_to_fetch", {31'd0, imem_req}, 32'd1);
      addrQueue.push_back(32'h0);

      // sequential stream, back-to-back handshakes
      applyStimulus(32'h2001_0001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h2002_0002, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h2003_0003, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h2004_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      // 0x10: j to index 0x40 -> 0x100
      applyStimulus({6'h02, 26'h40}, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      // 0x100: j back to 0x20
      applyStimulus({6'h02, 26'h8}, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      // 0x20: beq taken with imm -2 -> 0x1C
      applyStimulus({6'h04, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      // 0x1C: memory ack held off for three cycles
      applyStimulus(32'h0000_0020, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      // 0x20: beq not taken -> 0x24
      applyStimulus({6'h04, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      // 0x24: j back to 0x20
      applyStimulus({6'h02, 26'h8}, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      // 0x20: bne taken with imm 3 -> 0x30
      applyStimulus({6'h05, 5'd1, 5'd2, 16'h0003}, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      // 0x30: decode stalls five cycles, falls through -> 0x34
      applyStimulus(32'h2005_0005, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
      // 0x34: eq and ne both high, imm 4 -> 0x48
      applyStimulus({6'h04, 5'd3, 5'd4, 16'h0004}, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      // 0x48: jump outranks a taken branch -> 0x4
      applyStimulus({6'h02, 26'h1}, 0, 2, 1'b1, 1'b0, 1'b1, 1'b1);
      // 0x4: beq taken imm -3 wraps below zero -> 0xFFFFFFFC
      applyStimulus({6'h04, 5'd1, 5'd1, 16'hFFFD}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      // 0xFFFFFFFC: sequential wraps to 0
      applyStimulus(32'h2006_0006, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset while a fetch is outstanding, ack lands in the reset cycle
      pendingAddr = addrQueue.pop_front();
      checkOutput("pre_rst_req", {31'd0, imem_req}, 32'd1);
      checkOutput("pre_rst_addr", imem_addr, pendingAddr);
      tick();
      tick();
      checkOutput("pre_rst_wait", {31'd0, imem_req}, 32'd1);
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      checkOutput("mid_rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("mid_rst_instr", instr, 32'h0);
      checkOutput("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("mid_rst_pc_out", pc_out, 32'h0);
      reset = 1'b0;
      tick();
      imem_ack = 1'b0;
      checkOutput("idle_ack_ignored", instr, 32'h0);
      checkOutput("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("post_rst_req", {31'd0, imem_req}, 32'd1);
      checkOutput("post_rst_addr", imem_addr, 32'h0);
      addrQueue.push_back(32'h0);
      applyStimulus(32'h2007_0007, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("final_addr", imem_addr, 32'h4);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
